// File: rtl/carfield_regbus_pkg.sv
// Shared types and constants for the Carfield register-bus address responder.
// Rule fields are held at a fixed maximum width; narrower buses zero-extend into them.
package carfield_regbus_pkg;

  localparam int unsigned MaxAddrWidth = 64;
  localparam int unsigned CntWidth     = 16;
  localparam logic [31:0] ERR_DATA     = 32'hBADCAB1E;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    ERR  = 2'd2,
    RESP = 2'd3
  } state_e;

  typedef struct packed {
    logic [MaxAddrWidth-1:0] base;
    logic [MaxAddrWidth-1:0] size;
    logic                    en;
  } rule_t;

  function automatic logic [CntWidth-1:0] sat_inc(input logic [CntWidth-1:0] v);
    return (v == '1) ? v : v + CntWidth'(1);
  endfunction

endpackage

// File: rtl/carfield_regbus_addr_responder_if.sv
// Upstream register-bus request/response bundle between the host master and the responder.
interface carfield_regbus_addr_responder_if #(
  parameter int unsigned AddrWidth = 48,
  parameter int unsigned DataWidth = 32
);

  logic                   req_valid;
  logic                   req_write;
  logic [AddrWidth-1:0]   req_addr;
  logic [DataWidth-1:0]   req_wdata;
  logic [DataWidth/8-1:0] req_wstrb;
  logic                   rsp_ready;
  logic [DataWidth-1:0]   rsp_rdata;
  logic                   rsp_error;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_wstrb,
    input  rsp_ready, rsp_rdata, rsp_error
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_wstrb,
    output rsp_ready, rsp_rdata, rsp_error
  );

endinterface

// File: rtl/carfield_regbus_rule_match.sv
// Combinational base/size rule matcher; reports whether any enabled rule hits and the lowest hitting index.
module carfield_regbus_rule_match
  import carfield_regbus_pkg::*;
#(
  parameter int unsigned NumRules = 4,
  parameter int unsigned IdxWidth = (NumRules > 1) ? $clog2(NumRules) : 1
) (
  input  logic [MaxAddrWidth-1:0] addr_i,
  input  rule_t [NumRules-1:0]    rules_i,
  output logic                    match_o,
  output logic [IdxWidth-1:0]     idx_o
);

  logic [NumRules-1:0] hit;

  always_comb begin
    hit     = '0;
    match_o = 1'b0;
    idx_o   = '0;
    // End address is formed one bit wider so base+size at the top of the map cannot wrap.
    for (int i = 0; i < NumRules; i++) begin
      hit[i] = rules_i[i].en && (rules_i[i].size != '0) &&
               (addr_i >= rules_i[i].base) &&
               ({1'b0, addr_i} < ({1'b0, rules_i[i].base} + {1'b0, rules_i[i].size}));
    end
    for (int i = NumRules - 1; i >= 0; i--) begin
      if (hit[i]) begin
        match_o = 1'b1;
        idx_o   = IdxWidth'(i);
      end
    end
  end

endmodule

// File: rtl/carfield_regbus_addr_responder.sv
// Register-bus target-side decoder: registers each host request, routes it to one peripheral port,
// and answers unmapped or timed-out accesses locally with an error.
//
// state | meaning
// IDLE  | waiting for a host request; captures fields and decodes the address
// FWD   | one-hot valid to the selected peripheral, timeout counter running
// ERR   | no rule matched; load error response and bump decode-error count
// RESP  | one-cycle rsp_ready with latched rdata/error
module carfield_regbus_addr_responder
  import carfield_regbus_pkg::*;
#(
  parameter int unsigned          NumRules      = 4,
  parameter int unsigned          AddrWidth     = 48,
  parameter int unsigned          DataWidth     = 32,
  parameter int unsigned          TimeoutCycles = 255,
  parameter logic [DataWidth-1:0] ErrData       = DataWidth'(ERR_DATA)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NumRules*AddrWidth-1:0] rule_base_i,
  input  logic [NumRules*AddrWidth-1:0] rule_size_i,
  input  logic [NumRules-1:0]           rule_en_i,
  carfield_regbus_addr_responder_if.slave host,
  output logic [NumRules-1:0]           slv_valid_o,
  output logic                          slv_write_o,
  output logic [AddrWidth-1:0]          slv_addr_o,
  output logic [DataWidth-1:0]          slv_wdata_o,
  output logic [DataWidth/8-1:0]        slv_wstrb_o,
  input  logic [NumRules-1:0]           slv_ready_i,
  input  logic [NumRules*DataWidth-1:0] slv_rdata_i,
  input  logic [NumRules-1:0]           slv_error_i,
  output logic [CntWidth-1:0]           dec_err_cnt_o,
  output logic [CntWidth-1:0]           tmo_cnt_o
);

  localparam int unsigned IdxWidth = (NumRules > 1) ? $clog2(NumRules) : 1;
  localparam logic [7:0]  TmoLast  = 8'(TimeoutCycles - 1);

  state_e                 state_q, state_d;
  logic                   write_q, write_d;
  logic [AddrWidth-1:0]   addr_q, addr_d;
  logic [DataWidth-1:0]   wdata_q, wdata_d;
  logic [DataWidth/8-1:0] wstrb_q, wstrb_d;
  logic [IdxWidth-1:0]    sel_q, sel_d;
  logic [7:0]             tmo_q, tmo_d;
  logic [DataWidth-1:0]   rdata_q, rdata_d;
  logic                   error_q, error_d;
  logic [CntWidth-1:0]    dec_cnt_q, dec_cnt_d;
  logic [CntWidth-1:0]    tmo_cnt_q, tmo_cnt_d;

  rule_t [NumRules-1:0]   rules;
  logic                   match;
  logic [IdxWidth-1:0]    match_idx;
  logic [DataWidth-1:0]   sel_rdata;

  always_comb begin
    rules = '0;
    for (int i = 0; i < NumRules; i++) begin
      rules[i].base = MaxAddrWidth'(rule_base_i[i*AddrWidth +: AddrWidth]);
      rules[i].size = MaxAddrWidth'(rule_size_i[i*AddrWidth +: AddrWidth]);
      rules[i].en   = rule_en_i[i];
    end
  end

  // Decode runs on the incoming address so the FSM can branch in the capture cycle.
  carfield_regbus_rule_match #(
    .NumRules (NumRules),
    .IdxWidth (IdxWidth)
  ) u_rule_match (
    .addr_i  (MaxAddrWidth'(host.req_addr)),
    .rules_i (rules),
    .match_o (match),
    .idx_o   (match_idx)
  );

  assign sel_rdata = slv_rdata_i[32'(sel_q)*DataWidth +: DataWidth];

  always_comb begin
    state_d   = state_q;
    write_d   = write_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    sel_d     = sel_q;
    tmo_d     = tmo_q;
    rdata_d   = rdata_q;
    error_d   = error_q;
    dec_cnt_d = dec_cnt_q;
    tmo_cnt_d = tmo_cnt_q;
    case (state_q)
      IDLE: begin
        if (host.req_valid) begin
          write_d = host.req_write;
          addr_d  = host.req_addr;
          wdata_d = host.req_wdata;
          wstrb_d = host.req_wstrb;
          sel_d   = match_idx;
          tmo_d   = '0;
          state_d = match ? FWD : ERR;
        end
      end
      FWD: begin
        // Ready takes priority over a timeout landing in the same cycle.
        if (slv_ready_i[sel_q]) begin
          rdata_d = sel_rdata;
          error_d = slv_error_i[sel_q];
          state_d = RESP;
        end else if (tmo_q == TmoLast) begin
          rdata_d   = ErrData;
          error_d   = 1'b1;
          tmo_cnt_d = sat_inc(tmo_cnt_q);
          state_d   = RESP;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      ERR: begin
        rdata_d   = ErrData;
        error_d   = 1'b1;
        dec_cnt_d = sat_inc(dec_cnt_q);
        state_d   = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      write_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      sel_q     <= '0;
      tmo_q     <= '0;
      rdata_q   <= '0;
      error_q   <= 1'b0;
      dec_cnt_q <= '0;
      tmo_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      write_q   <= write_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      sel_q     <= sel_d;
      tmo_q     <= tmo_d;
      rdata_q   <= rdata_d;
      error_q   <= error_d;
      dec_cnt_q <= dec_cnt_d;
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  always_comb begin
    slv_valid_o = '0;
    if (state_q == FWD) slv_valid_o[sel_q] = 1'b1;
  end

  assign slv_write_o    = write_q;
  assign slv_addr_o     = addr_q;
  assign slv_wdata_o    = wdata_q;
  assign slv_wstrb_o    = wstrb_q;
  assign host.rsp_ready = (state_q == RESP);
  assign host.rsp_rdata = rdata_q;
  assign host.rsp_error = error_q;
  assign dec_err_cnt_o  = dec_cnt_q;
  assign tmo_cnt_o      = tmo_cnt_q;

endmodule

// File: tb/tb_carfield_regbus_addr_responder.sv
// Bench for the register-bus address responder: directed vector table, rule-config and reset
// sequences, then randomized traffic against a rule/latency reference model.
module tb_carfield_regbus_addr_responder;

  localparam int          NR   = 4;
  localparam int          AW   = 48;
  localparam int          DW   = 32;
  localparam int          TMO  = 255;
  localparam logic [31:0] ERRD = 32'hBADCAB1E;

  typedef struct {
    int          lat;
    logic [31:0] rd;
    logic        er;
    logic [3:0]  vmask;
    int          vcyc;
    bit          dinc;
    bit          tinc;
  } res_t;

  typedef struct {
    logic        wr;
    logic [47:0] a;
    int          k;
    logic [31:0] prd;
    logic        perr;
    res_t        exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic [NR*AW-1:0] rule_base_flat, rule_size_flat;
  logic [NR-1:0]    rule_en;
  logic [NR-1:0]    slv_valid, slv_ready, slv_error;
  logic             slv_write;
  logic [AW-1:0]    slv_addr;
  logic [DW-1:0]    slv_wdata;
  logic [DW/8-1:0]  slv_wstrb;
  logic [NR*DW-1:0] slv_rdata;
  logic [15:0]      dec_cnt, tmo_cnt;

  logic [47:0] r_base [NR];
  logic [47:0] r_size [NR];
  logic        r_en   [NR];

  int checks = 0;
  int errors = 0;
  int exp_dec = 0;
  int exp_tmo = 0;

  carfield_regbus_addr_responder_if #(.AddrWidth(AW), .DataWidth(DW)) bus ();

  carfield_regbus_addr_responder dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .rule_base_i   (rule_base_flat),
    .rule_size_i   (rule_size_flat),
    .rule_en_i     (rule_en),
    .host          (bus),
    .slv_valid_o   (slv_valid),
    .slv_write_o   (slv_write),
    .slv_addr_o    (slv_addr),
    .slv_wdata_o   (slv_wdata),
    .slv_wstrb_o   (slv_wstrb),
    .slv_ready_i   (slv_ready),
    .slv_rdata_i   (slv_rdata),
    .slv_error_i   (slv_error),
    .dec_err_cnt_o (dec_cnt),
    .tmo_cnt_o     (tmo_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic apply_rules();
    for (int i = 0; i < NR; i++) begin
      rule_base_flat[i*AW +: AW] = r_base[i];
      rule_size_flat[i*AW +: AW] = r_size[i];
      rule_en[i]                 = r_en[i];
    end
  endtask

  task automatic default_rules();
    r_base[0] = 48'h20010000; r_base[1] = 48'h20020000;
    r_base[2] = 48'h200A0000; r_base[3] = 48'h200B0000;
    for (int i = 0; i < NR; i++) begin
      r_size[i] = 48'h1000;
      r_en[i]   = 1'b1;
    end
    apply_rules();
  endtask

  function automatic res_t mkres(input int lat, input logic [31:0] rd, input logic er,
                                 input logic [3:0] vm, input int vc, input bit d, input bit t);
    res_t m;
    m.lat = lat; m.rd = rd; m.er = er; m.vmask = vm; m.vcyc = vc; m.dinc = d; m.tinc = t;
    return m;
  endfunction

  // Reference: first enabled, nonempty rule whose [base, base+size) holds the address;
  // latency 2+k when the peripheral answers within the timeout window, else 1+TMO.
  function automatic res_t model_txn(input logic [47:0] a, input int k,
                                     input logic [31:0] prd, input logic perr);
    int idx = -1;
    longint unsigned addr = 64'(a);
    for (int i = 0; i < NR; i++) begin
      longint unsigned lo = 64'(r_base[i]);
      longint unsigned hi = lo + 64'(r_size[i]);
      if (idx < 0 && r_en[i] && r_size[i] != 48'd0 && addr >= lo && addr < hi) idx = i;
    end
    if (idx < 0) return mkres(2, ERRD, 1'b1, 4'b0000, 0, 1'b1, 1'b0);
    if (k < 0 || k >= TMO) return mkres(1 + TMO, ERRD, 1'b1, 4'(1 << idx), TMO, 1'b0, 1'b1);
    return mkres(2 + k, prd, perr, 4'(1 << idx), k + 1, 1'b0, 1'b0);
  endfunction

  // Drives one request and plays the peripheral: the lane(s) seeing valid get prd, others ~prd;
  // ready is raised on the k-th valid cycle (k < 0: never).
  task automatic run_txn(input logic wr, input logic [47:0] a, input logic [31:0] wd,
                         input logic [3:0] ws, input int k, input logic [31:0] prd,
                         input logic perr, output res_t r, output logic [84:0] f);
    int fwd_n = 0;
    bit done = 1'b0;
    r = mkres(-1, 32'd0, 1'b0, 4'd0, 0, 1'b0, 1'b0);
    f = '0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = wr; bus.req_addr = a;
    bus.req_wdata = wd;   bus.req_wstrb = ws;
    for (int c = 1; c <= 300 && !done; c++) begin
      @(negedge clk);
      if (bus.rsp_ready) begin
        r.lat = c; r.rd = bus.rsp_rdata; r.er = bus.rsp_error;
        bus.req_valid = 1'b0;
        done = 1'b1;
      end
      if (slv_valid != '0) begin
        if (r.vcyc == 0) f = {slv_write, slv_addr, slv_wdata, slv_wstrb};
        r.vmask |= slv_valid;
        r.vcyc++;
        for (int i = 0; i < NR; i++) slv_rdata[i*DW +: DW] = slv_valid[i] ? prd : ~prd;
        slv_error = perr ? slv_valid : ~slv_valid;
        slv_ready = (k >= 0 && fwd_n == k) ? slv_valid : '0;
        fwd_n++;
      end else begin
        slv_ready = '0;
      end
    end
    bus.req_valid = 1'b0;
    slv_ready = '0;
  endtask

  task automatic do_txn(input string nm, input logic wr, input logic [47:0] a, input int k,
                        input logic [31:0] prd, input logic perr, input res_t e);
    res_t r;
    logic [84:0] f;
    logic [31:0] wd = $urandom;
    logic [3:0]  ws = 4'($urandom);
    run_txn(wr, a, wd, ws, k, prd, perr, r, f);
    if (e.dinc) exp_dec++;
    if (e.tinc) exp_tmo++;
    chk({nm, "_lat"},   128'(r.lat),   128'(e.lat));
    chk({nm, "_rdata"}, 128'(r.rd),    128'(e.rd));
    chk({nm, "_error"}, 128'(r.er),    128'(e.er));
    chk({nm, "_vmask"}, 128'(r.vmask), 128'(e.vmask));
    chk({nm, "_vcyc"},  128'(r.vcyc),  128'(e.vcyc));
    if (e.vmask != 4'd0) chk({nm, "_fields"}, 128'(f), 128'({wr, a, wd, ws}));
    @(negedge clk);
    chk({nm, "_rsp_one_cycle"}, 128'(bus.rsp_ready), 128'(1'b0));
    chk({nm, "_dec_cnt"}, 128'(dec_cnt), 128'(exp_dec));
    chk({nm, "_tmo_cnt"}, 128'(tmo_cnt), 128'(exp_tmo));
  endtask

  task automatic model_txn_run(input string nm, input logic wr, input logic [47:0] a,
                               input int k, input logic [31:0] prd, input logic perr);
    do_txn(nm, wr, a, k, prd, perr, model_txn(a, k, prd, perr));
  endtask

  vec_t vecs [10];

  initial begin
    vecs[0] = '{1'b0, 48'h20020004,   0, 32'h1234, 1'b0, mkres(2,   32'h1234, 1'b0, 4'b0010,   1, 1'b0, 1'b0)};
    vecs[1] = '{1'b1, 48'h200B0FFC,   3, 32'hCAFE, 1'b0, mkres(5,   32'hCAFE, 1'b0, 4'b1000,   4, 1'b0, 1'b0)};
    vecs[2] = '{1'b1, 48'h200B1000,   0, 32'h0,    1'b0, mkres(2,   ERRD,     1'b1, 4'b0000,   0, 1'b1, 1'b0)};
    vecs[3] = '{1'b0, 48'h30000000,   0, 32'h0,    1'b0, mkres(2,   ERRD,     1'b1, 4'b0000,   0, 1'b1, 1'b0)};
    vecs[4] = '{1'b0, 48'h20010000,   1, 32'hA5A5, 1'b1, mkres(3,   32'hA5A5, 1'b1, 4'b0001,   2, 1'b0, 1'b0)};
    vecs[5] = '{1'b0, 48'h200A0FFF,   0, 32'h77,   1'b0, mkres(2,   32'h77,   1'b0, 4'b0100,   1, 1'b0, 1'b0)};
    vecs[6] = '{1'b0, 48'h2001FFFF,   0, 32'h0,    1'b0, mkres(2,   ERRD,     1'b1, 4'b0000,   0, 1'b1, 1'b0)};
    vecs[7] = '{1'b0, 48'h20010040,  -1, 32'h0,    1'b0, mkres(256, ERRD,     1'b1, 4'b0001, 255, 1'b0, 1'b1)};
    vecs[8] = '{1'b0, 48'h20010040, 254, 32'h5555, 1'b0, mkres(256, 32'h5555, 1'b0, 4'b0001, 255, 1'b0, 1'b0)};
    vecs[9] = '{1'b0, 48'h20010044, 253, 32'h6666, 1'b0, mkres(255, 32'h6666, 1'b0, 4'b0001, 254, 1'b0, 1'b0)};

    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0;
    bus.req_wdata = '0;   bus.req_wstrb = '0;
    slv_ready = '0; slv_error = '0; slv_rdata = '0;
    rule_base_flat = '0; rule_size_flat = '0; rule_en = '0;
    default_rules();
    repeat (3) @(negedge clk);
    chk("rst_rsp_ready", 128'(bus.rsp_ready), 128'(1'b0));
    chk("rst_rsp_rdata", 128'(bus.rsp_rdata), 128'(32'd0));
    chk("rst_rsp_error", 128'(bus.rsp_error), 128'(1'b0));
    chk("rst_slv_valid", 128'(slv_valid), 128'(4'd0));
    chk("rst_slv_fields", 128'({slv_write, slv_addr, slv_wdata, slv_wstrb}), 128'(0));
    chk("rst_counters", 128'({dec_cnt, tmo_cnt}), 128'(0));
    rst = 1'b0;

    for (int i = 0; i < 10; i++)
      do_txn($sformatf("vec%0d", i), vecs[i].wr, vecs[i].a, vecs[i].k, vecs[i].prd,
             vecs[i].perr, vecs[i].exp);

    // Rule enable / overlap / empty-rule handling.
    r_en[1] = 1'b0; apply_rules();
    model_txn_run("dis1", 1'b0, 48'h20020000, 0, 32'h11, 1'b0);
    r_base[1] = 48'h20010000; r_en[1] = 1'b1; apply_rules();
    model_txn_run("ovl", 1'b0, 48'h20010000, 0, 32'h22, 1'b0);
    r_en[0] = 1'b0; apply_rules();
    model_txn_run("ovl_only1", 1'b0, 48'h20010000, 0, 32'h33, 1'b0);
    r_en[1] = 1'b0; apply_rules();
    model_txn_run("both_dis", 1'b0, 48'h20010000, 0, 32'h44, 1'b0);
    default_rules();
    r_size[2] = 48'd0; apply_rules();
    model_txn_run("size0", 1'b0, 48'h200A0000, 0, 32'h55, 1'b0);
    default_rules();

    // Reset while forwarding.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 48'h20010000;
    repeat (3) @(negedge clk);
    chk("rstfwd_pre_valid", 128'(slv_valid), 128'(4'b0001));
    rst = 1'b1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("rstfwd_valid", 128'(slv_valid), 128'(4'd0));
    chk("rstfwd_rsp_ready", 128'(bus.rsp_ready), 128'(1'b0));
    chk("rstfwd_counters", 128'({dec_cnt, tmo_cnt}), 128'(0));
    rst = 1'b0;
    exp_dec = 0;
    exp_tmo = 0;
    model_txn_run("post_rst", 1'b1, 48'h20020010, 2, 32'h9999, 1'b0);

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      int ri = $urandom_range(NR - 1);
      logic [47:0] a;
      logic [63:0] t;
      if (n % 10 == 5) begin
        for (int i = 0; i < NR; i++) r_en[i] = 1'($urandom);
        apply_rules();
      end
      case ($urandom_range(3))
        0: a = r_base[ri] + 48'($urandom_range(4095));
        1: a = r_base[ri] + r_size[ri];
        2: a = r_base[ri] - 48'd1;
        default: begin
          t = {$urandom, $urandom};
          a = t[47:0];
        end
      endcase
      model_txn_run($sformatf("rnd%0d", n), 1'($urandom), a, int'($urandom_range(5)),
                    $urandom, 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
